// File: rtl/heart_rate_meter.sv
// heart_rate_meter: windowed beat counter with scaled, double-dabble BCD readout.
// Define HR_DEBOUNCE_EN to insert a stability filter ahead of beat detection.
module heart_rate_meter #(
    parameter int NUM_DIGITS      = 4,
    parameter int WINDOW_CYCLES   = 1000,
    parameter int SCALE           = 1,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse,
    input  logic                    enable,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    valid,
    output logic                    overflow,
    output logic                    busy
);
    localparam int PROD_W = CNT_W + $clog2(SCALE + 1);
    localparam int WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int BIT_W  = $clog2(PROD_W + 1);
    localparam int BCD_W  = 4 * NUM_DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        if (n >= 20) return '1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0]      LIMIT = pow10(NUM_DIGITS);
    localparam logic [BCD_W-1:0] NINES = {NUM_DIGITS{4'h9}};

    if (WINDOW_CYCLES < PROD_W + 4) begin : g_bad_window
        $fatal(1, "heart_rate_meter: WINDOW_CYCLES must be at least PROD_W+4");
    end
    if (NUM_DIGITS < 1) begin : g_bad_digits
        $fatal(1, "heart_rate_meter: NUM_DIGITS must be at least 1");
    end
    if (PROD_W > 63 || SCALE < 1) begin : g_bad_scale
        $fatal(1, "heart_rate_meter: SCALE must be >= 1 and PROD_W <= 63");
    end
    if (DEBOUNCE_CYCLES < 0) begin : g_bad_debounce
        $fatal(1, "heart_rate_meter: DEBOUNCE_CYCLES must not be negative");
    end

    logic sync1, sync2, level, level_q, beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1   <= pulse;
            sync2   <= sync1;
            level_q <= level;
        end
    end

`ifdef HR_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db_len
        $fatal(1, "heart_rate_meter: DEBOUNCE_CYCLES must be at least 1");
    end

    logic            filt;
    logic [DB_W-1:0] db_cnt;

    // Filtered level follows sync2 only after a full run of disagreement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (sync2 == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt   <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    assign beat = level & ~level_q;

    logic [WIN_W-1:0] win;
    logic [CNT_W-1:0] edges;
    logic [CNT_W-1:0] snap;
    logic             tc;

    assign tc = enable && (win == WIN_W'(WINDOW_CYCLES - 1));

    // A beat on the terminal cycle seeds the next window instead of this one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win   <= '0;
            edges <= '0;
            snap  <= '0;
        end else if (!enable) begin
            win   <= '0;
            edges <= '0;
        end else if (tc) begin
            win   <= '0;
            snap  <= edges;
            edges <= CNT_W'(beat);
        end else begin
            win <= win + 1'b1;
            if (beat && !(&edges)) edges <= edges + 1'b1;
        end
    end

    typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

    state_t            state;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_nxt;
    logic [BCD_W-1:0]  dig;
    logic [BCD_W-1:0]  dig_nxt;
    logic [BIT_W-1:0]  bitn;
    logic              ovf;

    assign prod_nxt = PROD_W'(snap) * PROD_W'(SCALE);

    always_comb begin
        dig_nxt = dig;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_nxt[4*i +: 4] >= 4'd5)
                dig_nxt[4*i +: 4] = dig_nxt[4*i +: 4] + 4'd3;
        end
        dig_nxt = {dig_nxt[BCD_W-2:0], prod[PROD_W-1]};
    end

    // The last shift is folded into the DONE load so valid lands on DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prod     <= '0;
            dig      <= '0;
            bitn     <= '0;
            ovf      <= 1'b0;
            bcd      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tc) begin
                        state <= MUL;
                        busy  <= 1'b1;
                    end
                end
                MUL: begin
                    prod  <= prod_nxt;
                    ovf   <= (64'(prod_nxt) >= LIMIT);
                    dig   <= '0;
                    bitn  <= '0;
                    state <= CONV;
                end
                CONV: begin
                    dig  <= dig_nxt;
                    prod <= {prod[PROD_W-2:0], 1'b0};
                    bitn <= bitn + 1'b1;
                    if (bitn == BIT_W'(PROD_W - 1)) begin
                        state    <= DONE;
                        valid    <= 1'b1;
                        overflow <= ovf;
                        bcd      <= ovf ? NINES : dig_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heart_rate_meter.sv
// Bench for heart_rate_meter: three parameterisations share one stimulus,
// expected results are queued per window and matched against valid strobes.
module tb_heart_rate_meter;
    localparam int W    = 100;
    localparam int PW1  = 17;
    localparam int PW60 = 22;
`ifdef HR_DEBOUNCE_EN
    localparam int DLY = 4;
`else
    localparam int DLY = 0;
`endif

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        pulse  = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bcd1, bcd60;
    logic [7:0]  bcd2;
    logic        v1, v60, v2, o1, o60, o2, b1, b60, b2;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    typedef struct {
        logic [15:0] bcd;
        logic        ov;
        int          at;
    } exp_t;

    exp_t q1[$];
    exp_t q60[$];
    exp_t q2[$];

    heart_rate_meter #(.NUM_DIGITS(4), .WINDOW_CYCLES(W), .SCALE(1)) u1 (
        .clk(clk), .rst(rst), .pulse(pulse), .enable(enable),
        .bcd(bcd1), .valid(v1), .overflow(o1), .busy(b1)
    );
    heart_rate_meter #(.NUM_DIGITS(4), .WINDOW_CYCLES(W), .SCALE(60)) u60 (
        .clk(clk), .rst(rst), .pulse(pulse), .enable(enable),
        .bcd(bcd60), .valid(v60), .overflow(o60), .busy(b60)
    );
    heart_rate_meter #(.NUM_DIGITS(2), .WINDOW_CYCLES(W), .SCALE(60)) u2 (
        .clk(clk), .rst(rst), .pulse(pulse), .enable(enable),
        .bcd(bcd2), .valid(v2), .overflow(o2), .busy(b2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v, input int nd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] pulses(input int first, input int width,
                                            input int period, input int count);
        logic [W-1:0] p;
        p = '0;
        for (int k = 0; k < count; k++)
            for (int j = 0; j < width; j++)
                p[first + k*period + j] = 1'b1;
        return p;
    endfunction

    // Called at the negedge of window cycle 0; tc edge is W edges later.
    task automatic expect_window(input int n);
        exp_t e;
        int   tc;
        tc    = cyc + W;
        e.ov  = (n >= 10000);
        e.bcd = e.ov ? 16'h9999 : to_bcd(n, 4);
        e.at  = tc + PW1 + 1;
        q1.push_back(e);
        e.ov  = (n * 60 >= 10000);
        e.bcd = e.ov ? 16'h9999 : to_bcd(n * 60, 4);
        e.at  = tc + PW60 + 1;
        q60.push_back(e);
        e.ov  = (n * 60 >= 100);
        e.bcd = e.ov ? 16'h0099 : to_bcd(n * 60, 2);
        e.at  = tc + PW60 + 1;
        q2.push_back(e);
    endtask

    task automatic run_window(input logic [W-1:0] pat);
        for (int k = 0; k < W; k++) begin
            pulse = pat[k];
            @(negedge clk);
        end
    endtask

    task automatic stop_and_drain();
        enable = 1'b0;
        pulse  = 1'b0;
        repeat (40) @(negedge clk);
        nvec++;
        if (q1.size() + q60.size() + q2.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d/%0d/%0d results never strobed, required 0/0/0",
                     q1.size(), q60.size(), q2.size());
            q1.delete();
            q60.delete();
            q2.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v1) begin
            nvec++;
            if (q1.size() == 0) begin
                nerr++;
                $display("FAIL u1 strobe: unexpected valid at cycle %0d bcd=%h, required none", cyc, bcd1);
            end else begin
                e = q1.pop_front();
                if (bcd1 !== e.bcd || o1 !== e.ov || cyc !== e.at) begin
                    nerr++;
                    $display("FAIL u1 result: bcd=%h ov=%b cycle=%0d, required bcd=%h ov=%b cycle=%0d",
                             bcd1, o1, cyc, e.bcd, e.ov, e.at);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v60) begin
            nvec++;
            if (q60.size() == 0) begin
                nerr++;
                $display("FAIL u60 strobe: unexpected valid at cycle %0d bcd=%h, required none", cyc, bcd60);
            end else begin
                e = q60.pop_front();
                if (bcd60 !== e.bcd || o60 !== e.ov || cyc !== e.at) begin
                    nerr++;
                    $display("FAIL u60 result: bcd=%h ov=%b cycle=%0d, required bcd=%h ov=%b cycle=%0d",
                             bcd60, o60, cyc, e.bcd, e.ov, e.at);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v2) begin
            nvec++;
            if (q2.size() == 0) begin
                nerr++;
                $display("FAIL u2 strobe: unexpected valid at cycle %0d bcd=%h, required none", cyc, bcd2);
            end else begin
                e = q2.pop_front();
                if ({8'h00, bcd2} !== e.bcd || o2 !== e.ov || cyc !== e.at) begin
                    nerr++;
                    $display("FAIL u2 result: bcd=%h ov=%b cycle=%0d, required bcd=%h ov=%b cycle=%0d",
                             bcd2, o2, cyc, e.bcd[7:0], e.ov, e.at);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nvec++;
        if ({bcd1, v1, o1, b1} !== 19'h0) begin
            nerr++;
            $display("FAIL reset u1: bcd=%h v=%b ov=%b busy=%b, required all 0", bcd1, v1, o1, b1);
        end
        nvec++;
        if ({bcd60, v60, o60, b60} !== 19'h0) begin
            nerr++;
            $display("FAIL reset u60: bcd=%h v=%b ov=%b busy=%b, required all 0", bcd60, v60, o60, b60);
        end
        nvec++;
        if ({bcd2, v2, o2, b2} !== 11'h0) begin
            nerr++;
            $display("FAIL reset u2: bcd=%h v=%b ov=%b busy=%b, required all 0", bcd2, v2, o2, b2);
        end
        // Pulse held high across release: one beat, detected only after sync.
        pulse  = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        expect_window(1);
        run_window(pulses(0, 80, 1, 1));
        stop_and_drain();
    endtask

    task automatic test_basic();
        enable = 1'b1;
        expect_window(7);
        run_window(pulses(2, 4, 12, 7));
        stop_and_drain();
    endtask

    task automatic test_scale();
        enable = 1'b1;
        expect_window(3);
        run_window(pulses(5, 8, 20, 3));
        stop_and_drain();
    endtask

    task automatic test_overflow();
        enable = 1'b1;
        expect_window(2);
        run_window(pulses(5, 8, 20, 2));
        expect_window(1);
        run_window(pulses(5, 8, 20, 1));
        stop_and_drain();
    endtask

    task automatic test_terminal_beat();
        enable = 1'b1;
        expect_window(2);
        run_window(pulses(5, 8, 20, 2) | pulses(97 - DLY, 2 + DLY, 1, 1));
        expect_window(3);
        run_window(pulses(10, 8, 20, 2));
        stop_and_drain();
    endtask

    task automatic test_enable_hold();
        enable = 1'b1;
        expect_window(5);
        run_window(pulses(5, 8, 15, 5));
        enable = 1'b0;
        for (int k = 0; k < 3 * W; k++) begin
            pulse = (k % 10 < 5) && (k < 3 * W - 20);
            @(negedge clk);
        end
        nvec++;
        if (bcd1 !== 16'h0005 || bcd60 !== 16'h0300 || bcd2 !== 8'h99 || o2 !== 1'b1) begin
            nerr++;
            $display("FAIL enable hold: bcd %h/%h/%h ov2=%b, required 0005/0300/99 ov2=1",
                     bcd1, bcd60, bcd2, o2);
        end
        enable = 1'b1;
        expect_window(1);
        run_window(pulses(40, 8, 1, 1));
        stop_and_drain();
    endtask

    task automatic test_glitch();
        int n;
`ifdef HR_DEBOUNCE_EN
        n = 5;
`else
        n = 9;
`endif
        enable = 1'b1;
        expect_window(n);
        run_window(pulses(4, 8, 16, 5) | pulses(14, 1, 16, 4));
        stop_and_drain();
    endtask

    task automatic test_reset_midconv();
        enable = 1'b1;
        run_window(pulses(5, 8, 20, 3));
        repeat (5) @(negedge clk);
        nvec++;
        if ({b1, b60, b2} !== 3'b111) begin
            nerr++;
            $display("FAIL midconv busy: busy=%b%b%b, required 111", b1, b60, b2);
        end
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        nvec++;
        if ({bcd1, v1, o1, b1} !== 19'h0 || {bcd60, v60, o60, b60} !== 19'h0 ||
            {bcd2, v2, o2, b2} !== 11'h0) begin
            nerr++;
            $display("FAIL midconv reset: bcd %h/%h/%h busy %b%b%b ov %b%b%b, required all 0",
                     bcd1, bcd60, bcd2, b1, b60, b2, o1, o60, o2);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        stop_and_drain();
        nvec++;
        if (bcd1 !== 16'h0 || bcd60 !== 16'h0 || bcd2 !== 8'h0) begin
            nerr++;
            $display("FAIL midconv after: bcd %h/%h/%h, required 0/0/0", bcd1, bcd60, bcd2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scale();
        test_overflow();
        test_terminal_beat();
        test_enable_hold();
        test_glitch();
        test_reset_midconv();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
